// File: rtl/t48_timer.sv
// -----------------------------------------------------------------------------
// t48_timer
// 8-bit timer / event counter of the T48 core.
//   TIMER   : counter advances once every 2^PRESCALE_W machine cycles.
//   COUNTER : counter advances on each falling edge of T1, sampled once per
//             machine cycle.
//   STOP    : counter and prescaler hold.
// The counter is loaded by MOV T,A (write_timer_i) and read by MOV A,T
// (data_o). overflow_o pulses for one enabled cycle on every FF->00 wrap and
// feeds the interrupt controller directly.
//
// Ports
//   clk_i           core clock
//   res_i           asynchronous reset, active-high
//   en_clk_i        core clock enable; qualifies every state update
//   clk_mstate_i    machine state 0..4; state 2 is the per-cycle tick
//   t1_i            T1 pin, already synchronised
//   start_timer_i   STRT T
//   start_counter_i STRT CNT
//   stop_tcnt_i     STOP TCNT
//   write_timer_i   MOV T,A; load counter from data_i
//   data_i          load value
//   data_o          current counter value
//   overflow_o      counter wrapped FF->00
// -----------------------------------------------------------------------------
module t48_timer #(
    parameter int PRESCALE_W = 5
) (
    input  logic       clk_i,
    input  logic       res_i,
    input  logic       en_clk_i,
    input  logic [2:0] clk_mstate_i,
    input  logic       t1_i,
    input  logic       start_timer_i,
    input  logic       start_counter_i,
    input  logic       stop_tcnt_i,
    input  logic       write_timer_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       overflow_o
);

    typedef enum logic [1:0] {
        MODE_STOP    = 2'b00,
        MODE_TIMER   = 2'b01,
        MODE_COUNTER = 2'b10
    } mode_t;

    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    mode_t                 r_mode;
    logic [7:0]            r_cnt;
    logic [PRESCALE_W-1:0] r_pre;
    logic                  r_t1;
    logic                  r_ovf;

    logic w_tick;
    logic w_cmd;
    logic w_inc;

    // Tick strobe and increment request for the current enabled cycle.
    // A cycle carrying a mode command does no counting: the command owns it.
    always_comb begin
        w_tick = en_clk_i & (clk_mstate_i == 3'b010);
        w_cmd  = stop_tcnt_i | start_counter_i | start_timer_i;
        w_inc  = 1'b0;
        if (w_tick && !w_cmd) begin
            case (r_mode)
                MODE_TIMER:   w_inc = &r_pre;
                MODE_COUNTER: w_inc = r_t1 & ~t1_i;
                MODE_STOP:    w_inc = 1'b0;
                default:      w_inc = 1'b0;
            endcase
        end else begin
            w_inc = 1'b0;
        end
    end

    // Mode, prescaler, T1 history, counter and overflow state.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            r_mode <= MODE_STOP;
            r_cnt  <= 8'h00;
            r_pre  <= '0;
            r_t1   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (en_clk_i) begin
            // Mode commands: stop > start_counter > start_timer.
            if (stop_tcnt_i) begin
                r_mode <= MODE_STOP;
                if (w_tick) begin
                    r_t1 <= t1_i;
                end
            end else if (start_counter_i) begin
                r_mode <= MODE_COUNTER;
                r_t1   <= t1_i;          // fresh history: no spurious edge
            end else if (start_timer_i) begin
                r_mode <= MODE_TIMER;
                r_pre  <= '0;
            end else if (w_tick) begin
                case (r_mode)
                    MODE_TIMER:   r_pre <= r_pre + PRE_ONE;   // wraps at all-ones
                    MODE_COUNTER: r_t1  <= t1_i;
                    MODE_STOP:    r_t1  <= t1_i;
                    default:      r_mode <= MODE_STOP;        // illegal encoding
                endcase
            end

            // A write wins over a same-cycle increment and drops its overflow.
            if (write_timer_i) begin
                r_cnt <= data_i;
                r_ovf <= 1'b0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + 8'd1;
                r_ovf <= (r_cnt == 8'hFF);
            end else begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign data_o     = r_cnt;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_t48_timer.sv
module tb_t48_timer;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic [2:0] ms;
    logic       t1;
    logic       st, sc, sp, wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0=stop 1=timer 2=counter
    int m_mode;
    int m_ticks;     // ticks seen since the last timer start
    int m_t1;
    int m_cnt;
    int m_ovf;

    logic ovf_at_tick;

    t48_timer #(.PRESCALE_W(5)) dut (
        .clk_i          (clk),
        .res_i          (res),
        .en_clk_i       (en),
        .clk_mstate_i   (ms),
        .t1_i           (t1),
        .start_timer_i  (st),
        .start_counter_i(sc),
        .stop_tcnt_i    (sp),
        .write_timer_i  (wr),
        .data_i         (din),
        .data_o         (dout),
        .overflow_o     (ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_ticks = 0; m_t1 = 0; m_cnt = 0; m_ovf = 0;
    endtask

    // Apply one clock of stimulus and advance the model by the same rules.
    task automatic cyc(input logic i_en, input logic [2:0] i_ms, input logic i_t1,
                       input logic i_st, input logic i_sc, input logic i_sp,
                       input logic i_wr, input logic [7:0] i_d);
        bit inc;
        @(negedge clk);
        en = i_en; ms = i_ms; t1 = i_t1; st = i_st; sc = i_sc; sp = i_sp;
        wr = i_wr; din = i_d;
        @(posedge clk);
        if (i_en) begin
            inc = 0;
            if (i_sp) m_mode = 0;
            else if (i_sc) begin m_mode = 2; m_t1 = i_t1; end
            else if (i_st) begin m_mode = 1; m_ticks = 0; end
            else if (i_ms == 3'd2) begin
                if (m_mode == 1) begin
                    m_ticks++;
                    inc = (m_ticks % 32 == 0);
                end else if (m_mode == 2) begin
                    inc = (m_t1 == 1 && i_t1 == 1'b0);
                    m_t1 = i_t1;
                end
            end
            m_ovf = 0;
            if (i_wr) m_cnt = i_d;
            else if (inc) begin
                if (m_cnt == 255) m_ovf = 1;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        #1;
    endtask

    // One enabled machine cycle (states 0..4, tick at state 2).
    task automatic mcycle(input logic i_t1);
        for (int s = 0; s < 5; s++) begin
            cyc(1'b1, 3'(s), i_t1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (s == 2) ovf_at_tick = ovf;
        end
    endtask

    task automatic cmd(input logic i_st, input logic i_sc, input logic i_sp,
                       input logic i_wr, input logic [7:0] i_d, input logic i_t1);
        cyc(1'b1, 3'd0, i_t1, i_st, i_sc, i_sp, i_wr, i_d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dout !== 8'h00 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_values got %h/%b want 00/0", dout, ovf);
        end
        // Run mid-operation, then reset asynchronously between edges.
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) mcycle(1'b0);
        checks++;
        if (dout !== 8'h81) begin
            errors++; $display("FAIL pre_reset_count got %h want 81", dout);
        end
        @(negedge clk);
        #2 res = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dout !== 8'h00 || ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset got %h/%b want 00/0", dout, ovf);
        end
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 40; i++) mcycle(1'b0);
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_stopped got %h want 00", dout);
        end
    endtask

    task automatic test_timer_wrap();
        do_reset();
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            mcycle(1'b0);
            if (i == 31) begin
                checks++;
                if (dout !== 8'hFE) begin
                    errors++; $display("FAIL timer_tick31 got %h want FE", dout);
                end
            end
            if (i == 32) begin
                checks++;
                if (dout !== 8'hFF || ovf_at_tick !== 1'b0) begin
                    errors++; $display("FAIL timer_tick32 got %h/%b want FF/0", dout, ovf_at_tick);
                end
            end
        end
        checks++;
        if (dout !== 8'h00 || ovf_at_tick !== 1'b1) begin
            errors++; $display("FAIL timer_wrap got %h/%b want 00/1", dout, ovf_at_tick);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_one_cycle got %b want 0", ovf);
        end
    endtask

    task automatic test_counter();
        do_reset();
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        mcycle(1'b1);
        mcycle(1'b0);
        mcycle(1'b1);
        checks++;
        if (dout !== 8'h01) begin
            errors++; $display("FAIL counter_rise_ignored got %h want 01", dout);
        end
        mcycle(1'b0);
        mcycle(1'b1);
        mcycle(1'b0);
        checks++;
        if (dout !== 8'h03) begin
            errors++; $display("FAIL counter_three got %h want 03", dout);
        end
    endtask

    task automatic test_write_priority();
        do_reset();
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        mcycle(1'b1);
        cyc(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        checks++;
        if (dout !== 8'h55 || ovf !== 1'b0) begin
            errors++; $display("FAIL write_priority got %h/%b want 55/0", dout, ovf);
        end
    endtask

    task automatic test_stop_resume();
        do_reset();
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) mcycle(1'b0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) mcycle(1'b0);
        checks++;
        if (dout !== 8'h10) begin
            errors++; $display("FAIL stop_hold got %h want 10", dout);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 31; i++) mcycle(1'b0);
        checks++;
        if (dout !== 8'h10) begin
            errors++; $display("FAIL resume_31 got %h want 10", dout);
        end
        mcycle(1'b0);
        checks++;
        if (dout !== 8'h11) begin
            errors++; $display("FAIL resume_32 got %h want 11", dout);
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 31; i++) mcycle(1'b0);
        cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (dout !== 8'h00 || ovf !== 1'b1) begin
            errors++; $display("FAIL gate_setup got %h/%b want 00/1", dout, ovf);
        end
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 3'd2, i[0], i == 1, i == 2, i == 3, 1'b1, 8'hA5);
        checks++;
        if (dout !== 8'h00 || ovf !== 1'b1) begin
            errors++; $display("FAIL gate_hold got %h/%b want 00/1", dout, ovf);
        end
        cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL gate_ovf_clear got %b want 0", ovf);
        end
        // Prescaler kept its place: 31 more ticks reach the next increment.
        cyc(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 31; i++) mcycle(1'b0);
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL gate_pre_31 got %h want 00", dout);
        end
        mcycle(1'b0);
        checks++;
        if (dout !== 8'h01) begin
            errors++; $display("FAIL gate_pre_32 got %h want 01", dout);
        end
    endtask

    task automatic test_random();
        logic [2:0] r_ms;
        logic r_en, r_t1, r_st, r_sc, r_sp, r_wr;
        logic [7:0] r_d;
        int k;
        do_reset();
        r_ms = 3'd0;
        r_t1 = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            r_en = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) r_t1 = $urandom % 2;
            r_st = 0; r_sc = 0; r_sp = 0;
            if (r_ms != 3'd2 && ($urandom % 60) == 0) begin
                k = $urandom % 4;
                r_st = (k == 0 || k == 3); r_sc = (k == 1 || k == 3); r_sp = (k == 2);
            end
            r_wr = ($urandom % 120) == 0;
            r_d  = 8'(($urandom % 2) ? (8'hF8 | 8'($urandom % 8)) : $urandom);
            cyc(r_en, r_ms, r_t1, r_st, r_sc, r_sp, r_wr, r_d);
            checks++;
            if (dout !== 8'(m_cnt) || ovf !== 1'(m_ovf)) begin
                errors++;
                $display("FAIL random_%0d got %h/%b want %h/%0d", i, dout, ovf, 8'(m_cnt), m_ovf);
            end
            if (r_en) r_ms = (r_ms == 3'd4) ? 3'd0 : r_ms + 3'd1;
        end
    endtask

    initial begin
        res = 1'b1; en = 1'b0; ms = 3'd0; t1 = 1'b0;
        st = 1'b0; sc = 1'b0; sp = 1'b0; wr = 1'b0; din = 8'h00;
        ovf_at_tick = 1'b0;
        model_reset();
        test_reset();
        test_timer_wrap();
        test_counter();
        test_write_priority();
        test_stop_resume();
        test_enable_gating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
